// File: rtl/event_readout_ctrl.sv
// Event readout controller.
//
// When capture_done reports a complete event in the buffer, this block sends it out
// as a stream of 32-bit beats. The stream is one header beat {8'hA5, 8'h00, event_cnt},
// followed by BEATS beats for each of the NUM_WORDS buffer words. Words are read
// oldest first (address NUM_WORDS-1 down to 0), and each word is sent LSB beat first.
//
// Ports:
//   rd_clk        clock for the whole block
//   rst           asynchronous, active-high reset
//   capture_done  single-cycle pulse: the buffer holds a complete event
//   buf_data      buffer read data, valid RD_LATENCY clocks after read_addr
//   read_addr     buffer read address (registered)
//   out_data      beat data (registered)
//   out_valid     beat valid
//   out_ready     downstream accept
//   out_last      final beat of the event
//   busy          readout in progress
//   event_cnt     events fully read out (wraps)
//   drop_cnt      capture_done pulses ignored while busy (saturates)
module event_readout_ctrl #(
    parameter int unsigned NUM_WORDS  = 64,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned BEATS      = 24
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  capture_done,
    input  logic [BEATS*32-1:0]   buf_data,
    output logic [5:0]            read_addr,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [15:0]           event_cnt,
    output logic [7:0]            drop_cnt
);

    localparam int unsigned WordW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned BeatW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned ShiftW = BEATS * 32;

    localparam logic [WordW-1:0] LastWord = WordW'(NUM_WORDS - 1);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);
    localparam logic [1:0]       LastWait = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StFetch,
        StWait,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WordW-1:0]  word_q, word_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [1:0]        wait_q, wait_d;
    logic [ShiftW-1:0] shift_q, shift_d;
    logic [5:0]        addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic [15:0]       event_cnt_q, event_cnt_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        event_cnt_d = event_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (capture_done) begin
                    state_d = StHeader;
                    word_d  = '0;
                    beat_d  = '0;
                    // The header travels through the shift register so out_data
                    // always comes straight from shift_q[31:0].
                    shift_d = {{(ShiftW - 32){1'b0}}, 8'hA5, 8'h00, event_cnt_q};
                end
            end
            StHeader: begin
                if (out_ready) begin
                    state_d = StFetch;
                    addr_d  = 6'(LastWord - word_q);
                end
            end
            StFetch: begin
                state_d = StWait;
                wait_d  = '0;
            end
            StWait: begin
                // WAIT lasts RD_LATENCY cycles, so buf_data is sampled in the cycle
                // RD_LATENCY clocks after read_addr was first presented.
                if (wait_q == LastWait) begin
                    shift_d = buf_data;
                    state_d = StShift;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StShift: begin
                if (out_ready) begin
                    shift_d = shift_q >> 32;
                    if (beat_q == LastBeat) begin
                        beat_d = '0;
                        if (word_q == LastWord) begin
                            state_d = StDone;
                        end else begin
                            word_d  = word_q + WordW'(1);
                            addr_d  = 6'(LastWord - (word_q + WordW'(1)));
                            state_d = StFetch;
                        end
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            StDone: begin
                state_d     = StIdle;
                event_cnt_d = event_cnt_q + 16'd1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Any pulse outside IDLE is lost, including one in the DONE cycle.
        if (capture_done && (state_q != StIdle) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        valid_d = (state_d == StHeader) || (state_d == StShift);
        last_d  = (state_d == StShift) && (beat_d == LastBeat) && (word_d == LastWord);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            word_q      <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            event_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            event_cnt_q <= event_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign read_addr = addr_q;
    assign out_data  = shift_q[31:0];
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign event_cnt = event_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_event_readout_ctrl.sv
// Directed bench for event_readout_ctrl.
//
// There are three instances, with read latencies 2, 1 and 4. Each has its own
// buffer model: the read address passes through RD_LATENCY flops, and the word at
// address a holds beat b = {a, b[4:0], 21'h0}. The sel input chooses which instance
// receives capture_done and which one is observed.
module tb_event_readout_ctrl;

    localparam int unsigned NumWords = 64;
    localparam int unsigned Beats    = 24;
    localparam int unsigned Total    = 1 + NumWords * Beats;
    localparam int unsigned Budget   = 20000;

    logic rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic       rst;
    logic       cap;
    logic       out_ready;
    logic [1:0] sel;

    logic [767:0] buf_l2, buf_l1, buf_l4;
    logic [5:0]   ra_l2, ra_l1, ra_l4;
    logic [31:0]  od_l2, od_l1, od_l4;
    logic         ov_l2, ov_l1, ov_l4;
    logic         ol_l2, ol_l1, ol_l4;
    logic         bz_l2, bz_l1, bz_l4;
    logic [15:0]  ec_l2, ec_l1, ec_l4;
    logic [7:0]   dc_l2, dc_l1, dc_l4;

    event_readout_ctrl #(.NUM_WORDS(NumWords), .RD_LATENCY(2), .BEATS(Beats)) u_dut_l2 (
        .rd_clk(rd_clk), .rst(rst), .capture_done(cap && (sel == 2'd0)), .buf_data(buf_l2),
        .read_addr(ra_l2), .out_data(od_l2), .out_valid(ov_l2), .out_ready(out_ready),
        .out_last(ol_l2), .busy(bz_l2), .event_cnt(ec_l2), .drop_cnt(dc_l2)
    );
    event_readout_ctrl #(.NUM_WORDS(NumWords), .RD_LATENCY(1), .BEATS(Beats)) u_dut_l1 (
        .rd_clk(rd_clk), .rst(rst), .capture_done(cap && (sel == 2'd1)), .buf_data(buf_l1),
        .read_addr(ra_l1), .out_data(od_l1), .out_valid(ov_l1), .out_ready(out_ready),
        .out_last(ol_l1), .busy(bz_l1), .event_cnt(ec_l1), .drop_cnt(dc_l1)
    );
    event_readout_ctrl #(.NUM_WORDS(NumWords), .RD_LATENCY(4), .BEATS(Beats)) u_dut_l4 (
        .rd_clk(rd_clk), .rst(rst), .capture_done(cap && (sel == 2'd2)), .buf_data(buf_l4),
        .read_addr(ra_l4), .out_data(od_l4), .out_valid(ov_l4), .out_ready(out_ready),
        .out_last(ol_l4), .busy(bz_l4), .event_cnt(ec_l4), .drop_cnt(dc_l4)
    );

    function automatic logic [767:0] make_word(input logic [5:0] a);
        logic [767:0] w;
        logic [4:0]   b5;
        w = '0;
        for (int b = 0; b < 24; b++) begin
            b5 = 5'(b);
            w[b*32 +: 32] = {a, b5, 21'h0};
        end
        return w;
    endfunction

    // Buffer read pipelines: data appears RD_LATENCY clocks after the address.
    logic [5:0] pipe_l1;
    logic [5:0] pipe_l2 [2];
    logic [5:0] pipe_l4 [4];
    always @(posedge rd_clk) begin
        pipe_l1    <= ra_l1;
        pipe_l2[0] <= ra_l2;
        pipe_l2[1] <= pipe_l2[0];
        pipe_l4[0] <= ra_l4;
        for (int i = 1; i < 4; i++) pipe_l4[i] <= pipe_l4[i-1];
    end
    always_comb begin
        buf_l1 = make_word(pipe_l1);
        buf_l2 = make_word(pipe_l2[1]);
        buf_l4 = make_word(pipe_l4[3]);
    end

    logic [5:0]  obs_addr;
    logic [31:0] obs_data;
    logic        obs_valid, obs_last, obs_busy;
    logic [15:0] obs_ecnt;
    logic [7:0]  obs_dcnt;
    always_comb begin
        obs_addr = ra_l2; obs_data = od_l2; obs_valid = ov_l2; obs_last = ol_l2;
        obs_busy = bz_l2; obs_ecnt = ec_l2; obs_dcnt = dc_l2;
        case (sel)
            2'd1: begin
                obs_addr = ra_l1; obs_data = od_l1; obs_valid = ov_l1; obs_last = ol_l1;
                obs_busy = bz_l1; obs_ecnt = ec_l1; obs_dcnt = dc_l1;
            end
            2'd2: begin
                obs_addr = ra_l4; obs_data = od_l4; obs_valid = ov_l4; obs_last = ol_l4;
                obs_busy = bz_l4; obs_ecnt = ec_l4; obs_dcnt = dc_l4;
            end
            default: ;
        endcase
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    // Expected beat k of an event whose header carries cnt.
    function automatic logic [31:0] exp_beat(input int k, input logic [15:0] cnt);
        int         idx;
        logic [5:0] a;
        logic [4:0] b;
        if (k == 0) return {8'hA5, 8'h00, cnt};
        idx = k - 1;
        a   = 6'(63 - idx / 24);
        b   = 5'(idx % 24);
        return {a, b, 21'h0};
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(obs_addr), 32'h0);
        chk({tag, "_data"}, obs_data, 32'h0);
        chk({tag, "_valid"}, 32'(obs_valid), 32'h0);
        chk({tag, "_last"}, 32'(obs_last), 32'h0);
        chk({tag, "_busy"}, 32'(obs_busy), 32'h0);
        chk({tag, "_ecnt"}, 32'(obs_ecnt), 32'h0);
        chk({tag, "_dcnt"}, 32'(obs_dcnt), 32'h0);
    endtask

    // Runs one event on the selected instance. Beats are checked at each handshake.
    // Data and last are checked to hold while stalled. Every inter-beat gap must be
    // lat+1 cycles. capture_done is pulsed in cycles [drop_from, drop_from+drop_n)
    // and, if drop_done is set, in the DONE cycle. A nonzero abort_at returns once
    // that many beats have been accepted.
    task automatic run_event(input logic [15:0] exp_cnt, input int unsigned rdy_pct,
                             input int unsigned lat, input int drop_from, input int drop_n,
                             input bit drop_done, input int abort_at);
        int          beat    = 0;
        int          gap     = 0;
        int          cyc     = 0;
        bit          stalled = 0;
        logic [31:0] held_d  = '0;
        logic        held_l  = 1'b0;
        cap = 1'b1;
        tick();
        cap = 1'b0;
        chk("busy_start", 32'(obs_busy), 32'h1);
        while (beat < int'(Total) && cyc < int'(Budget)) begin
            if (abort_at > 0 && beat == abort_at) return;
            cap       = (cyc >= drop_from) && (cyc < drop_from + drop_n);
            out_ready = ($urandom_range(99) < rdy_pct);
            if (obs_valid) begin
                if (gap != 0) begin
                    chk("gap", 32'(gap), 32'(lat + 1));
                    gap = 0;
                end
                if (stalled) begin
                    chk("hold_data", obs_data, held_d);
                    chk("hold_last", 32'(obs_last), 32'(held_l));
                end
                if (out_ready) begin
                    chk("beat_data", obs_data, exp_beat(beat, exp_cnt));
                    chk("beat_last", 32'(obs_last), 32'(beat == int'(Total) - 1));
                    beat++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held_d  = obs_data;
                    held_l  = obs_last;
                end
            end else begin
                if (stalled) chk("valid_held", 32'(obs_valid), 32'h1);
                stalled = 0;
                if (beat > 0) gap++;
            end
            tick();
            cyc++;
        end
        chk("beat_count", 32'(beat), 32'(Total));
        // DONE cycle
        cap       = drop_done;
        out_ready = 1'b1;
        chk("done_valid", 32'(obs_valid), 32'h0);
        chk("done_busy", 32'(obs_busy), 32'h1);
        tick();
        cap = 1'b0;
        chk("idle_busy", 32'(obs_busy), 32'h0);
        chk("event_cnt", 32'(obs_ecnt), 32'(16'(exp_cnt + 16'd1)));
        repeat (20) begin
            chk("no_header", 32'(obs_valid), 32'h0);
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        cap       = 1'b0;
        out_ready = 1'b0;
        sel       = 2'd0;
        repeat (3) @(posedge rd_clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Basic event, then the same stream under 30% ready.
        run_event(16'd0, 100, 2, 0, 0, 1'b0, 0);
        chk("drop_basic", 32'(obs_dcnt), 32'h0);
        run_event(16'd1, 30, 2, 0, 0, 1'b0, 0);

        // Drops: one mid-event and one in the DONE cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_event(16'd0, 100, 2, 100, 1, 1'b1, 0);
        chk("drop_two", 32'(obs_dcnt), 32'h2);
        chk("drop_ecnt", 32'(obs_ecnt), 32'h1);

        // Reset mid-cycle during word 10, beat 5.
        run_event(16'd1, 100, 2, 0, 0, 1'b0, 1 + 10 * 24 + 5);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(posedge rd_clk);
        #1;
        rst = 1'b0;
        tick();
        run_event(16'd0, 100, 2, 0, 0, 1'b0, 0);

        // event_cnt wrap, plus 300 drops saturating drop_cnt.
        force u_dut_l2.event_cnt_q = 16'hFFFF;
        tick();
        release u_dut_l2.event_cnt_q;
        chk("preload", 32'(obs_ecnt), 32'h0000FFFF);
        run_event(16'hFFFF, 100, 2, 10, 300, 1'b0, 0);
        chk("drop_sat", 32'(obs_dcnt), 32'hFF);

        // Latency sweep.
        sel = 2'd1;
        tick();
        run_event(16'd0, 100, 1, 0, 0, 1'b0, 0);
        sel = 2'd2;
        tick();
        run_event(16'd0, 60, 4, 0, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
